// File: rtl/ex_mem_req.sv
// EX-stage memory-request issuer: latches ID load/store ops, runs the data-SRAM req/addr_ok handshake
// and swallows data_ok of flush-orphaned requests. Optional misaligned-access check: EX_ALE_CHECK_EN.
module ex_mem_req (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_to_ex_valid,
  output logic        ex_allowin,
  input  logic [31:0] id_pc,
  input  logic        id_op_ld,
  input  logic        id_op_st,
  input  logic [1:0]  id_size,
  input  logic        id_ld_unsigned,
  input  logic [31:0] id_base,
  input  logic [31:0] id_offset,
  input  logic [31:0] id_st_data,
  input  logic        id_rf_we,
  input  logic [4:0]  id_rf_waddr,
  input  logic        id_excep_en,
  input  logic        mem_allowin,
  output logic        ex_to_mem_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_addr,
  output logic [1:0]  ex_size,
  output logic        ex_ld_unsigned,
  output logic        ex_res_from_mem,
  output logic        ex_rf_we,
  output logic [4:0]  ex_rf_waddr,
  output logic        ex_sram_requed,
  output logic        ex_excep_en,
  output logic [5:0]  ex_ecode,
  output logic [31:0] ex_badv,
  input  logic        mem_cancel,
  input  logic        mem_req_pending,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        mem_data_ok
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_REQ_F = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             ex_valid;
  logic             op_st;
  logic             excep_in;
  logic [31:0]      st_data;
  logic [CNT_W-1:0] discard_cnt, discard_nxt;
  logic [SUM_W-1:0] discard_sum;

  logic need_req, start, sram_acc, ready_go, handoff;
  logic orphan_done, discard_dec;

  // Op latch: datapath fields advance whenever EX accepts from ID
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_pc           <= '0;
      ex_addr         <= '0;
      ex_size         <= '0;
      ex_ld_unsigned  <= 1'b0;
      ex_res_from_mem <= 1'b0;
      op_st           <= 1'b0;
      st_data         <= '0;
      ex_rf_we        <= 1'b0;
      ex_rf_waddr     <= '0;
      excep_in        <= 1'b0;
    end else if (id_to_ex_valid && ex_allowin) begin
      ex_pc           <= id_pc;
      ex_addr         <= id_base + id_offset;
      ex_size         <= id_size;
      ex_ld_unsigned  <= id_ld_unsigned;
      ex_res_from_mem <= id_op_ld;
      op_st           <= id_op_st;
      st_data         <= id_st_data;
      ex_rf_we        <= id_rf_we;
      ex_rf_waddr     <= id_rf_waddr;
      excep_in        <= id_excep_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)         ex_valid <= 1'b0;
    else if (flush)      ex_valid <= 1'b0;
    else if (ex_allowin) ex_valid <= id_to_ex_valid;
  end

`ifdef EX_ALE_CHECK_EN
  localparam logic [5:0] ECODE_ALE = 6'h09;
  logic misalign, ale;
  assign misalign = ((ex_size == 2'd1) && ex_addr[0]) ||
                    ((ex_size == 2'd2) && (ex_addr[1:0] != 2'b00));
  assign ale         = (ex_res_from_mem | op_st) & misalign & ~excep_in;
  assign ex_excep_en = excep_in | ale;
  assign ex_ecode    = ale ? ECODE_ALE : 6'h00;
  assign ex_badv     = ale ? ex_addr : 32'h0;
`else
  assign ex_excep_en = excep_in;
  assign ex_ecode    = 6'h00;
  assign ex_badv     = 32'h0;
`endif

  // Request payload comes straight from the latched op, so it is stable while req is held
  always_comb begin
    data_sram_wdata = st_data;
    data_sram_wstrb = 4'b0000;
    case (ex_size)
      2'd0:    data_sram_wdata = {4{st_data[7:0]}};
      2'd1:    data_sram_wdata = {2{st_data[15:0]}};
      default: data_sram_wdata = st_data;
    endcase
    if (op_st) begin
      case (ex_size)
        2'd0:    data_sram_wstrb = 4'b0001 << ex_addr[1:0];
        2'd1:    data_sram_wstrb = 4'b0011 << {ex_addr[1], 1'b0};
        default: data_sram_wstrb = 4'b1111;
      endcase
    end
  end

  assign data_sram_wr   = op_st;
  assign data_sram_size = ex_size;
  assign data_sram_addr = ex_addr;

  assign need_req      = ex_valid & (ex_res_from_mem | op_st) & ~ex_excep_en;
  assign start         = need_req & (state == S_IDLE) & ~mem_cancel & ~flush &
                         (discard_cnt == '0);
  assign data_sram_req = start | (state == S_REQ) | (state == S_REQ_F);
  assign sram_acc      = data_sram_req & data_sram_addr_ok;

  assign ready_go        = ~need_req | (mem_cancel & (state == S_IDLE)) |
                           (state == S_DONE) | sram_acc;
  assign ex_allowin      = resetn & (state != S_REQ_F) & (~ex_valid | (ready_go & mem_allowin));
  assign ex_to_mem_valid = ex_valid & ready_go & ~flush;
  assign handoff         = ex_to_mem_valid & mem_allowin;
  assign ex_sram_requed  = ex_valid & ((state == S_DONE) | sram_acc);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!data_sram_addr_ok) state_nxt = S_REQ;
          else if (!handoff)      state_nxt = S_DONE;
        end
      end
      S_REQ: begin
        if (data_sram_addr_ok) state_nxt = (handoff || flush) ? S_IDLE : S_DONE;
        else if (flush)        state_nxt = S_REQ_F;
      end
      S_REQ_F: begin
        if (data_sram_addr_ok) state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (handoff || flush) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Each orphaned request (including MEM's pending one at flush) costs one swallowed data_ok
  assign orphan_done = (flush & ((state == S_DONE) | ((state == S_REQ) & data_sram_addr_ok))) |
                       ((state == S_REQ_F) & data_sram_addr_ok);
  assign discard_dec = data_sram_data_ok & (discard_cnt != '0);

  always_comb begin
    discard_sum = SUM_W'(discard_cnt) + SUM_W'(flush & mem_req_pending) +
                  SUM_W'(orphan_done) - SUM_W'(discard_dec);
    discard_nxt = (discard_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : discard_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) discard_cnt <= '0;
    else         discard_cnt <= discard_nxt;
  end

  assign mem_data_ok = resetn & data_sram_data_ok & (discard_cnt == '0);

endmodule

// File: tb/tb_ex_mem_req.sv
// Bench for ex_mem_req: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an op-level behavioural model.
module tb_ex_mem_req;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, id_to_ex_valid, id_op_ld, id_op_st, id_ld_unsigned, id_rf_we, id_excep_en;
  logic [31:0] id_pc, id_base, id_offset, id_st_data;
  logic [1:0]  id_size;
  logic [4:0]  id_rf_waddr;
  logic        mem_allowin, mem_cancel, mem_req_pending, flush, data_sram_addr_ok, data_sram_data_ok;
  logic        ex_allowin, ex_to_mem_valid, ex_ld_unsigned, ex_res_from_mem, ex_rf_we;
  logic        ex_sram_requed, ex_excep_en, data_sram_req, data_sram_wr, mem_data_ok;
  logic [31:0] ex_pc, ex_addr, ex_badv, data_sram_addr, data_sram_wdata;
  logic [1:0]  ex_size, data_sram_size;
  logic [4:0]  ex_rf_waddr;
  logic [5:0]  ex_ecode;
  logic [3:0]  data_sram_wstrb;

  ex_mem_req dut (
    .clk(clk), .resetn(resetn), .id_to_ex_valid(id_to_ex_valid), .ex_allowin(ex_allowin),
    .id_pc(id_pc), .id_op_ld(id_op_ld), .id_op_st(id_op_st), .id_size(id_size),
    .id_ld_unsigned(id_ld_unsigned), .id_base(id_base), .id_offset(id_offset),
    .id_st_data(id_st_data), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .id_excep_en(id_excep_en), .mem_allowin(mem_allowin), .ex_to_mem_valid(ex_to_mem_valid),
    .ex_pc(ex_pc), .ex_addr(ex_addr), .ex_size(ex_size), .ex_ld_unsigned(ex_ld_unsigned),
    .ex_res_from_mem(ex_res_from_mem), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_sram_requed(ex_sram_requed), .ex_excep_en(ex_excep_en), .ex_ecode(ex_ecode),
    .ex_badv(ex_badv), .mem_cancel(mem_cancel), .mem_req_pending(mem_req_pending),
    .flush(flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .mem_data_ok(mem_data_ok)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(input logic st, input logic [1:0] sz, input logic [1:0] a);
    if (!st) return 4'b0000;
    case (sz)
      2'd0:    return 4'(1 << a);
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Behavioural model: the op sitting in EX, whether its request is held/accepted,
  // whether an orphaned request is still waiting for addr_ok, and how many data_ok to swallow.
  logic        m_valid, m_ld, m_st, m_uns, m_we, m_exc, m_acc, m_iss, m_orph;
  logic [31:0] m_pc, m_addr, m_data;
  logic [1:0]  m_size;
  logic [4:0]  m_waddr;
  int          m_disc;

  always @(negedge clk) begin : model
    logic ale, need, cstart, req, acc, rgo, alw, tom;
    int   inc, dec;
    if (!resetn) begin
      m_valid = 0; m_acc = 0; m_iss = 0; m_orph = 0; m_disc = 0;
      m_ld = 0; m_st = 0; m_uns = 0; m_we = 0; m_exc = 0;
      m_pc = 0; m_addr = 0; m_data = 0; m_size = 0; m_waddr = 0;
    end else begin
`ifdef EX_ALE_CHECK_EN
      ale = (m_ld | m_st) & ~m_exc &
            (((m_size == 2'd1) && m_addr[0]) || ((m_size == 2'd2) && (m_addr[1:0] != 2'b00)));
`else
      ale = 1'b0;
`endif
      need   = m_valid & (m_ld | m_st) & ~(m_exc | ale);
      cstart = need & ~m_acc & ~m_iss & ~mem_cancel & ~flush & (m_disc == 0);
      req    = cstart | m_iss | m_orph;
      acc    = req & data_sram_addr_ok;
      rgo    = ~need | (mem_cancel & ~m_iss & ~m_acc) | m_acc | acc;
      alw    = ~m_orph & (~m_valid | (rgo & mem_allowin));
      tom    = m_valid & rgo & ~flush;

      chk("allowin", 32'(ex_allowin), 32'(alw));
      chk("to_mem", 32'(ex_to_mem_valid), 32'(tom));
      chk("req", 32'(data_sram_req), 32'(req));
      chk("mem_data_ok", 32'(mem_data_ok), 32'(data_sram_data_ok && m_disc == 0));
      if (req) begin
        chk("req_addr", data_sram_addr, m_addr);
        chk("req_wr", 32'(data_sram_wr), 32'(m_st));
        chk("req_size", 32'(data_sram_size), 32'(m_size));
        chk("req_wstrb", 32'(data_sram_wstrb), 32'(exp_strb(m_st, m_size, m_addr[1:0])));
        if (m_st) chk("req_wdata", data_sram_wdata, exp_wdata(m_size, m_data));
      end
      if (tom) begin
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_addr", ex_addr, m_addr);
        chk("ex_size", 32'(ex_size), 32'(m_size));
        chk("ex_uns", 32'(ex_ld_unsigned), 32'(m_uns));
        chk("ex_ld", 32'(ex_res_from_mem), 32'(m_ld));
        chk("ex_we", 32'(ex_rf_we), 32'(m_we));
        chk("ex_waddr", 32'(ex_rf_waddr), 32'(m_waddr));
        chk("ex_requed", 32'(ex_sram_requed), 32'(m_acc | acc));
        chk("ex_exc", 32'(ex_excep_en), 32'(m_exc | ale));
        chk("ex_ecode", 32'(ex_ecode), ale ? 32'h9 : 32'h0);
        chk("ex_badv", ex_badv, ale ? m_addr : 32'h0);
      end

      inc = int'(flush & mem_req_pending) + int'(flush & m_valid & (m_acc | acc)) +
            int'(m_orph & data_sram_addr_ok);
      dec = int'(data_sram_data_ok && m_disc > 0);
      m_disc = m_disc + inc - dec;
      if (m_disc > 3) m_disc = 3;

      m_orph = m_orph ? ~data_sram_addr_ok : (m_iss & flush & ~data_sram_addr_ok);
      m_iss  = (cstart | m_iss) & ~data_sram_addr_ok & ~flush;
      m_acc  = (flush | alw) ? 1'b0 : (m_acc | (acc & m_valid));
      if (id_to_ex_valid && alw) begin
        m_pc = id_pc; m_addr = id_base + id_offset; m_size = id_size; m_uns = id_ld_unsigned;
        m_ld = id_op_ld; m_st = id_op_st; m_data = id_st_data; m_we = id_rf_we;
        m_waddr = id_rf_waddr; m_exc = id_excep_en;
      end
      m_valid = flush ? 1'b0 : (alw ? id_to_ex_valid : m_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_to_ex_valid = 0; id_op_ld = 0; id_op_st = 0; id_size = 0; id_ld_unsigned = 0;
    id_base = 0; id_offset = 0; id_st_data = 0; id_rf_we = 0; id_rf_waddr = 0; id_excep_en = 0;
    id_pc = 0; mem_allowin = 1; mem_cancel = 0; mem_req_pending = 0; flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic put_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] d);
    id_to_ex_valid = 1; id_op_ld = ld; id_op_st = st; id_size = sz; id_base = base;
    id_offset = off; id_st_data = d; id_pc = base ^ 32'h8000_0000; id_rf_we = ld;
    id_rf_waddr = 5'd7; id_ld_unsigned = 0; id_excep_en = 0;
  endtask

  int outs = 0;

  initial begin
    quiet();
    resetn = 0;
    data_sram_data_ok = 1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_allowin", 32'(ex_allowin), 32'h0);
    chk("rst_to_mem", 32'(ex_to_mem_valid), 32'h0);
    chk("rst_req", 32'(data_sram_req), 32'h0);
    chk("rst_pc", ex_pc, 32'h0);
    chk("rst_wstrb", 32'(data_sram_wstrb), 32'h0);
    chk("rst_data_ok", 32'(mem_data_ok), 32'h0);
    chk("rst_requed", 32'(ex_sram_requed), 32'h0);
    step(); quiet(); resetn = 1;
    @(negedge clk);

    // Word load, addr_ok in the first request cycle
    step(); put_op(1, 0, 2'd2, 32'h1000, 32'h4, 32'h0);
    @(negedge clk); chk("s1_allowin", 32'(ex_allowin), 32'h1);
    step(); quiet(); data_sram_addr_ok = 1;
    @(negedge clk);
    chk("s1_req", 32'(data_sram_req), 32'h1);
    chk("s1_addr", data_sram_addr, 32'h1004);
    chk("s1_wstrb", 32'(data_sram_wstrb), 32'h0);
    chk("s1_requed", 32'(ex_sram_requed), 32'h1);
    chk("s1_to_mem", 32'(ex_to_mem_valid), 32'h1);
    step(); quiet();
    @(negedge clk); chk("s1_req_after", 32'(data_sram_req), 32'h0);

    // Byte store at ...3, addr_ok held off for three cycles
    step(); put_op(0, 1, 2'd0, 32'h2000, 32'h3, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      step(); quiet();
      @(negedge clk);
      chk("s2_req_held", 32'(data_sram_req), 32'h1);
      chk("s2_wstrb", 32'(data_sram_wstrb), 32'h8);
      chk("s2_wdata", data_sram_wdata, 32'hABAB_ABAB);
      chk("s2_addr", data_sram_addr, 32'h2003);
      chk("s2_to_mem", 32'(ex_to_mem_valid), 32'h0);
    end
    step(); quiet(); data_sram_addr_ok = 1;
    @(negedge clk);
    chk("s2_req_last", 32'(data_sram_req), 32'h1);
    chk("s2_to_mem_go", 32'(ex_to_mem_valid), 32'h1);
    step(); quiet();
    @(negedge clk); chk("s2_req_after", 32'(data_sram_req), 32'h0);

    // Accepted load waits in DONE while MEM stalls
    step(); put_op(1, 0, 2'd2, 32'h3000, 32'h10, 32'h0);
    step(); quiet(); data_sram_addr_ok = 1; mem_allowin = 0;
    @(negedge clk); chk("s3_allowin", 32'(ex_allowin), 32'h0);
    step(); quiet(); mem_allowin = 0;
    @(negedge clk);
    chk("s3_req_done", 32'(data_sram_req), 32'h0);
    chk("s3_requed", 32'(ex_sram_requed), 32'h1);
    chk("s3_to_mem", 32'(ex_to_mem_valid), 32'h1);
    step(); quiet();
    @(negedge clk); chk("s3_allowin_go", 32'(ex_allowin), 32'h1);
    step(); quiet();
    @(negedge clk); chk("s3_gone", 32'(ex_to_mem_valid), 32'h0);

    // Flush in REQ with MEM pending: two data_ok swallowed, start blocked meanwhile
    step(); put_op(1, 0, 2'd2, 32'h4000, 32'h0, 32'h0);
    step(); quiet();
    step(); quiet(); flush = 1; mem_req_pending = 1;
    @(negedge clk); chk("s4_to_mem_flush", 32'(ex_to_mem_valid), 32'h0);
    step(); quiet(); put_op(1, 0, 2'd2, 32'h4100, 32'h0, 32'h0);
    @(negedge clk);
    chk("s4_reqf_allowin", 32'(ex_allowin), 32'h0);
    chk("s4_reqf_req", 32'(data_sram_req), 32'h1);
    step(); data_sram_addr_ok = 1;
    step(); data_sram_addr_ok = 0;
    step(); quiet(); data_sram_data_ok = 1;
    @(negedge clk);
    chk("s4_blocked1", 32'(data_sram_req), 32'h0);
    chk("s4_swallow1", 32'(mem_data_ok), 32'h0);
    step(); quiet(); data_sram_data_ok = 1;
    @(negedge clk);
    chk("s4_blocked2", 32'(data_sram_req), 32'h0);
    chk("s4_swallow2", 32'(mem_data_ok), 32'h0);
    step(); quiet(); data_sram_addr_ok = 1;
    @(negedge clk); chk("s4_restart", 32'(data_sram_req), 32'h1);
    step(); quiet(); data_sram_data_ok = 1;
    @(negedge clk); chk("s4_pass_data_ok", 32'(mem_data_ok), 32'h1);

    // mem_cancel in IDLE: store passes without a request
    step(); put_op(0, 1, 2'd2, 32'h5000, 32'h0, 32'h1234_5678);
    step(); quiet(); mem_cancel = 1;
    @(negedge clk);
    chk("s5_req", 32'(data_sram_req), 32'h0);
    chk("s5_to_mem", 32'(ex_to_mem_valid), 32'h1);
    chk("s5_requed", 32'(ex_sram_requed), 32'h0);

    // Half load at an odd address
    step(); put_op(1, 0, 2'd1, 32'h2000, 32'h1, 32'h0);
    step(); quiet(); data_sram_addr_ok = 1;
    @(negedge clk);
`ifdef EX_ALE_CHECK_EN
    chk("s6_req", 32'(data_sram_req), 32'h0);
    chk("s6_exc", 32'(ex_excep_en), 32'h1);
    chk("s6_ecode", 32'(ex_ecode), 32'h9);
    chk("s6_badv", ex_badv, 32'h2001);
`else
    chk("s6_req", 32'(data_sram_req), 32'h1);
    chk("s6_addr", data_sram_addr, 32'h2001);
    chk("s6_badv", ex_badv, 32'h0);
`endif
    chk("s6_to_mem", 32'(ex_to_mem_valid), 32'h1);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      step();
      id_to_ex_valid    = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       begin id_op_ld = 1; id_op_st = 0; end
        1:       begin id_op_ld = 0; id_op_st = 1; end
        2:       begin id_op_ld = 0; id_op_st = 0; end
        default: begin id_op_ld = 1; id_op_st = 0; end
      endcase
      id_size           = 2'($urandom_range(0, 2));
      id_ld_unsigned    = 1'($urandom_range(0, 1));
      id_base           = $urandom;
      id_offset         = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31)) : $urandom;
      id_st_data        = $urandom;
      id_pc             = $urandom;
      id_rf_we          = 1'($urandom_range(0, 1));
      id_rf_waddr       = 5'($urandom_range(0, 31));
      id_excep_en       = ($urandom_range(0, 99) < 5);
      mem_allowin       = ($urandom_range(0, 99) < 70);
      mem_cancel        = ($urandom_range(0, 99) < 5);
      flush             = ($urandom_range(0, 99) < 4);
      mem_req_pending   = ($urandom_range(0, 99) < 30);
      data_sram_addr_ok = ($urandom_range(0, 99) < 40);
      data_sram_data_ok = (outs > 0) && ($urandom_range(0, 99) < 50);
      @(negedge clk);
      if (data_sram_req && data_sram_addr_ok) outs++;
      if (flush && mem_req_pending) outs++;
      if (data_sram_data_ok) outs--;
    end

    step(); quiet();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_req.md
Name: ex_mem_req

Overview:
- EX-stage memory-request issuer; sits directly upstream of the MEM stage.
- Latches an ID-stage load/store op and computes effective address, byte strobes and aligned store data.
- Issues a single data-SRAM request with a req/addr_ok handshake, then hands off to MEM with a "request outstanding" flag.
- Tracks requests orphaned by a flush and swallows their data_ok responses.

Parameters:
- none.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_to_ex_valid  in  1  ID has an op
- ex_allowin  out  1  EX can accept
- id_pc  in  32  op PC
- id_op_ld  in  1  load
- id_op_st  in  1  store
- id_size  in  2  0 byte, 1 half, 2 word
- id_ld_unsigned  in  1  zero-extend load
- id_base  in  32  base register value
- id_offset  in  32  sign-extended offset
- id_st_data  in  32  store source value
- id_rf_we  in  1  writes regfile
- id_rf_waddr  in  5  destination
- id_excep_en  in  1  earlier exception carried
- mem_allowin  in  1  MEM can accept
- ex_to_mem_valid  out  1  EX hands op to MEM
- ex_pc  out  32  latched PC
- ex_addr  out  32  effective address
- ex_size  out  2  latched size
- ex_ld_unsigned  out  1  latched
- ex_res_from_mem  out  1  latched load flag
- ex_rf_we  out  1  latched
- ex_rf_waddr  out  5  latched
- ex_sram_requed  out  1  request accepted for this op
- ex_excep_en  out  1  exception
- ex_ecode  out  6  exception code
- ex_badv  out  32  bad address
- mem_cancel  in  1  exception/ertn in MEM or WB; no new request
- mem_req_pending  in  1  MEM holds an accepted request awaiting data_ok
- flush  in  1  pipeline flush
- data_sram_req  out  1  request
- data_sram_wr  out  1  store
- data_sram_size  out  2  size
- data_sram_addr  out  32  address
- data_sram_wstrb  out  4  byte strobes
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response
- mem_data_ok  out  1  data_ok after filtering

Behaviour:
- Reset clears ex_valid, state (IDLE) and discard_cnt; all outputs are 0.
- Datapath registers load when id_to_ex_valid & ex_allowin.
- ex_valid: cleared by flush; otherwise it loads id_to_ex_valid when ex_allowin.
- Address and store data:
  - ex_addr = base + offset, mod 2^32.
  - Store data is replicated per size: byte = {4{d[7:0]}}, half = {2{d[15:0]}}.
  - wstrb: byte = 0001 << addr[1:0]; half = 0011 << {addr[1],1'b0}; word = 1111. Loads use wstrb 0000.
- need_req = ex_valid & (ld|st) & ~ex_excep_en.
- start = need_req & state==IDLE & ~mem_cancel & ~flush & discard_cnt==0.
- data_sram_req = start | state==REQ | state==REQ_F. Address/size/wr/wstrb/wdata stay stable while req is high.
- States and transitions:
  - IDLE & start & ~addr_ok -> REQ.
  - IDLE & start & addr_ok: hand-off this cycle -> IDLE, else -> DONE.
  - REQ & addr_ok: hand-off -> IDLE, else -> DONE.
  - REQ & flush -> REQ_F. req is held until addr_ok and is never withdrawn.
  - REQ_F & addr_ok -> IDLE; discard_cnt +1.
  - DONE & hand-off -> IDLE.
  - DONE & flush -> IDLE; discard_cnt +1.
- ex_ready_go = ~need_req | mem_cancel_at_idle | state==DONE | (req & addr_ok). mem_cancel_at_idle = mem_cancel & state==IDLE; the op passes with no request.
- ex_allowin = ~ex_valid | ex_ready_go & mem_allowin. Forced 0 in REQ_F.
- ex_to_mem_valid = ex_valid & ex_ready_go & ~flush.
- ex_sram_requed = 1 iff a request was accepted for this op (addr_ok seen).
- discard_cnt (2 bits):
  - At flush, add mem_req_pending plus 1 if EX is in DONE or addr_ok is accepted in the same cycle.
  - Decrement on data_sram_data_ok when nonzero.
  - Simultaneous increment and decrement are netted. Saturates at 3.
- mem_data_ok = data_sram_data_ok & discard_cnt==0.
- Flush in IDLE with no request: EX just invalidates.

Optional Feature:
- Macro EX_ALE_CHECK_EN.
- Defined:
  - Misalignment is half & addr[0], or word & addr[1:0]!=0.
  - A misaligned op with no prior exception sets ex_excep_en=1, ex_ecode=6'h09, ex_badv=ex_addr.
  - No request is issued.
- Undefined:
  - No check; ex_badv=0.
  - The request is issued with the unmodified address.

Test Plan:
- Word load, base=0x1000, offset=0x4, addr_ok same cycle, mem_allowin=1 -> req one cycle; addr=0x1004, wstrb=0000, ex_sram_requed=1; next state IDLE.
- Byte store, data=0x000000AB, addr=0x...3, addr_ok delayed 3 cycles -> req held 4 cycles with stable fields; wstrb=1000, wdata=0xABABABAB.
- Load accepted, mem_allowin=0 for 2 cycles -> state DONE; req low after addr_ok; hands off when mem_allowin=1.
- Flush while in REQ, mem_req_pending=1 -> discard_cnt=1, then 2 at addr_ok; the next two data_ok are swallowed (mem_data_ok=0); new start is blocked until cnt=0.
- mem_cancel=1 with a store in IDLE -> no req; the op passes to MEM with ex_sram_requed=0.
- EX_ALE_CHECK_EN defined, half load at 0x2001 -> no req; ecode=0x09, badv=0x2001.
